// File: rtl/stack_mem_responder_if.sv
// Controller <-> memory responder bus.
//   cs         : chip select, active-low
//   we         : 1 = write, 0 = read (qualified by cs = 0)
//   address    : word address
//   data_in    : write data
//   data_out   : registered read data
//   data_valid : one-cycle pulse marking fresh read data
//   busy       : high while the post-reset clear sweep runs
interface stack_mem_responder_if #(
   parameter int unsigned ADDR_WIDTH = 7,
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  cs;
   logic                  we;
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_valid;
   logic                  busy;

   modport master (
      output cs, we, address, data_in,
      input  data_out, data_valid, busy
   );

   modport slave (
      input  cs, we, address, data_in,
      output data_out, data_valid, busy
   );
endinterface

// File: rtl/stack_mem_responder.sv
// Memory-side responder for the stack calculator controller bus.
// 2**ADDR_WIDTH x DATA_WIDTH synchronous store with a registered one-cycle
// read path. Every reset starts a clear sweep that writes CLEAR_VALUE to all
// locations; requests are ignored while busy is high.
//   clk     : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of stack_mem_responder_if
module stack_mem_responder #(
   parameter int unsigned          ADDR_WIDTH  = 7,
   parameter int unsigned          DATA_WIDTH  = 8,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   stack_mem_responder_if.slave  bus
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [DATA_WIDTH-1:0] data_out_q;
   logic                  data_valid_q;
   logic                  busy_q;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  mem_we_c;
   logic [ADDR_WIDTH-1:0] mem_addr_c;
   logic [DATA_WIDTH-1:0] mem_wdata_c;

   // Single write port shared by the clear sweep and controller writes.
   always_comb begin
      mem_we_c    = 1'b0;
      mem_addr_c  = '0;
      mem_wdata_c = '0;
      if (state == CLEAR) begin
         mem_we_c    = 1'b1;
         mem_addr_c  = ptr;
         mem_wdata_c = CLEAR_VALUE;
      end else if (!bus.cs && bus.we) begin
         mem_we_c    = 1'b1;
         mem_addr_c  = bus.address;
         mem_wdata_c = bus.data_in;
      end
   end

   // Storage is not reset; the sweep clears it. No writes while in reset.
   always_ff @(posedge clk) begin
      if (mem_we_c && reset_n) begin
         mem[mem_addr_c] <= mem_wdata_c;
      end
   end

   // Control FSM with registered read data, valid pulse and busy flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= CLEAR;
         ptr          <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         busy_q       <= 1'b1;
      end else begin
         data_valid_q <= 1'b0;
         case (state)
            CLEAR: begin
               ptr <= ptr + ADDR_WIDTH'(1);
               if (ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                  state  <= READY;
                  busy_q <= 1'b0;
               end
            end
            READY: begin
               // Writes land in the store on this edge, so a read on the
               // next edge sees them without any bypass path.
               if (!bus.cs && !bus.we) begin
                  data_out_q   <= mem[bus.address];
                  data_valid_q <= 1'b1;
               end
            end
            default: begin
               state  <= CLEAR;
               ptr    <= '0;
               busy_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.data_out   = data_out_q;
   assign bus.data_valid = data_valid_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_stack_mem_responder.sv
// Self-checking bench for stack_mem_responder against a behavioural model.
module tb_stack_mem_responder;

   localparam int unsigned AW    = 7;
   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 1 << AW;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model state
   logic [DW-1:0] model_mem [DEPTH];
   int            sweep_left;
   logic [DW-1:0] exp_dout;
   logic          exp_valid;
   logic          exp_busy;

   stack_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   stack_mem_responder #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .CLEAR_VALUE(8'h00)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Drive one request, advance one rising edge, update the model, settle.
   task automatic step(input logic c, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
      bus.cs      = c;
      bus.we      = w;
      bus.address = a;
      bus.data_in = d;
      @(posedge clk);
      if (sweep_left > 0) begin
         model_mem[DEPTH - sweep_left] = 8'h00;
         sweep_left--;
         exp_valid = 1'b0;
      end else if (!c && w) begin
         model_mem[a] = d;
         exp_valid    = 1'b0;
      end else if (!c && !w) begin
         exp_dout  = model_mem[a];
         exp_valid = 1'b1;
      end else begin
         exp_valid = 1'b0;
      end
      exp_busy = (sweep_left != 0);
      #1;
   endtask

   task automatic idle();
      step(1'b1, 1'b0, '0, '0);
   endtask

   // Assert reset (called at posedge+1), check immediate effect, release.
   task automatic apply_reset(input string tag);
      reset_n = 1'b0;
      #1;
      sweep_left = DEPTH;
      exp_dout   = '0;
      exp_valid  = 1'b0;
      exp_busy   = 1'b1;
      n_checks++;
      if (bus.busy !== 1'b1) begin
         n_errors++; $display("FAIL %s busy: got %b want 1", tag, bus.busy);
      end
      n_checks++;
      if (bus.data_out !== 8'h00) begin
         n_errors++; $display("FAIL %s data_out: got %h want 00", tag, bus.data_out);
      end
      n_checks++;
      if (bus.data_valid !== 1'b0) begin
         n_errors++; $display("FAIL %s data_valid: got %b want 0", tag, bus.data_valid);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset("reset");
   endtask

   // Full sweep; a write at edge 10 must be dropped.
   task automatic test_sweep();
      for (int k = 1; k <= int'(DEPTH); k++) begin
         if (k == 10) step(1'b0, 1'b1, 7'd3, 8'h3C);
         else idle();
         n_checks++;
         if (bus.busy !== exp_busy) begin
            n_errors++; $display("FAIL sweep_busy edge %0d: got %b want %b", k, bus.busy, exp_busy);
         end
         if (k == int'(DEPTH) - 1) begin
            n_checks++;
            if (bus.busy !== 1'b1) begin
               n_errors++; $display("FAIL sweep_busy_127: got %b want 1", bus.busy);
            end
         end
         if (k == int'(DEPTH)) begin
            n_checks++;
            if (bus.busy !== 1'b0) begin
               n_errors++; $display("FAIL sweep_busy_128: got %b want 0", bus.busy);
            end
         end
         n_checks++;
         if (bus.data_valid !== 1'b0) begin
            n_errors++; $display("FAIL sweep_valid edge %0d: got %b want 0", k, bus.data_valid);
         end
      end
   endtask

   task automatic test_cleared();
      logic [AW-1:0] addrs [4];
      addrs[0] = 7'd0; addrs[1] = 7'd64; addrs[2] = 7'd127; addrs[3] = 7'd3;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, addrs[i], '0);
         n_checks++;
         if (bus.data_out !== 8'h00 || bus.data_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL cleared_read addr %0d: got %h/%b want 00/1", addrs[i], bus.data_out, bus.data_valid);
         end
      end
      idle();
      n_checks++;
      if (bus.data_valid !== 1'b0) begin
         n_errors++; $display("FAIL cleared_valid_drop: got %b want 0", bus.data_valid);
      end
   endtask

   task automatic test_write_read();
      step(1'b0, 1'b1, 7'd7, 8'hA5);
      n_checks++;
      if (bus.data_valid !== 1'b0) begin
         n_errors++; $display("FAIL wr_valid: got %b want 0", bus.data_valid);
      end
      step(1'b0, 1'b0, 7'd7, '0);
      n_checks++;
      if (bus.data_out !== 8'hA5 || bus.data_valid !== 1'b1) begin
         n_errors++; $display("FAIL raw_read: got %h/%b want a5/1", bus.data_out, bus.data_valid);
      end
      idle();
      n_checks++;
      if (bus.data_valid !== 1'b0 || bus.data_out !== 8'hA5) begin
         n_errors++; $display("FAIL raw_after: got %h/%b want a5/0", bus.data_out, bus.data_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] vals [3];
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, AW'(i), vals[i]);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, AW'(i), '0);
         n_checks++;
         if (bus.data_out !== vals[i] || bus.data_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_read %0d: got %h/%b want %h/1", i, bus.data_out, bus.data_valid, vals[i]);
         end
      end
   endtask

   task automatic test_hold();
      step(1'b0, 1'b0, 7'd1, '0);
      n_checks++;
      if (bus.data_out !== 8'h22 || bus.data_valid !== 1'b1) begin
         n_errors++; $display("FAIL hold_read: got %h/%b want 22/1", bus.data_out, bus.data_valid);
      end
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
         n_checks++;
         if (bus.data_out !== 8'h22 || bus.data_valid !== 1'b0) begin
            n_errors++; $display("FAIL hold_cycle %0d: got %h/%b want 22/0", i, bus.data_out, bus.data_valid);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, 15)), DW'($urandom));
         n_checks++;
         if (bus.data_out !== exp_dout || bus.data_valid !== exp_valid || bus.busy !== exp_busy) begin
            n_errors++;
            $display("FAIL random %0d: got %h/%b/%b want %h/%b/%b", i, bus.data_out, bus.data_valid,
                     bus.busy, exp_dout, exp_valid, exp_busy);
         end
      end
   endtask

   task automatic test_reset_mid();
      step(1'b0, 1'b1, 7'd127, 8'hFF);
      step(1'b0, 1'b0, 7'd127, '0);
      n_checks++;
      if (bus.data_out !== 8'hFF || bus.data_valid !== 1'b1) begin
         n_errors++; $display("FAIL mid_pre_read: got %h/%b want ff/1", bus.data_out, bus.data_valid);
      end
      apply_reset("reset1");
      for (int k = 0; k < 50; k++) idle();
      apply_reset("reset_mid");
      for (int k = 1; k <= int'(DEPTH); k++) begin
         step(1'b0, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
         n_checks++;
         if (bus.busy !== exp_busy || bus.data_valid !== 1'b0 || bus.data_out !== 8'h00) begin
            n_errors++;
            $display("FAIL mid_sweep edge %0d: got %b/%b/%h want %b/0/00", k, bus.busy,
                     bus.data_valid, bus.data_out, exp_busy);
         end
      end
      step(1'b0, 1'b0, 7'd127, '0);
      n_checks++;
      if (bus.data_out !== 8'h00 || bus.data_valid !== 1'b1) begin
         n_errors++; $display("FAIL mid_read127: got %h/%b want 00/1", bus.data_out, bus.data_valid);
      end
   endtask

   initial begin
      bus.cs      = 1'b1;
      bus.we      = 1'b0;
      bus.address = '0;
      bus.data_in = '0;
      for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 8'hXX;
      #1;
      test_reset();
      test_sweep();
      test_cleared();
      test_write_read();
      test_back_to_back();
      test_hold();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/stack_mem_responder.md
# stack_mem_responder

Memory-side responder for the stack calculator's controller bus. It serves the controller's chip-select / write-enable / address / data protocol with a 128 x 8 synchronous store and a registered one-cycle read path. After every reset it runs a hardware clear sweep, so the controller always starts from an empty, known stack image. It sits between the controller and the shared data bus, in the position of the memory module.

## Interface
Parameters:
- ADDR_WIDTH, 7: address bits; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8: word width.
- CLEAR_VALUE, 8'h00: value written to every location by the post-reset sweep.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- cs, input, 1: chip select, active-low; a request is present when cs = 0.
- we, input, 1: 1 = write request, 0 = read request; qualified by cs = 0.
- address, input, ADDR_WIDTH: word address.
- data_in, input, DATA_WIDTH: write data.
- data_out, output, DATA_WIDTH: registered read data.
- data_valid, output, 1: one-cycle pulse marking fresh read data on data_out.
- busy, output, 1: high while the clear sweep runs; requests are ignored.

## Operation
- FSM states are CLEAR and READY. Reset forces CLEAR with the sweep pointer at 0.
- CLEAR:
  - Each edge writes CLEAR_VALUE to mem[ptr] and increments ptr.
  - On the edge that writes location DEPTH-1, the FSM moves to READY.
  - busy = 1 for the whole state. cs, we, address and data_in are ignored.
  - data_valid = 0 and data_out holds its value.
- READY, request decode on each edge:
  - cs = 0, we = 1: mem[address] <= data_in. data_out is unchanged and data_valid = 0 next cycle.
  - cs = 0, we = 0: data_out <= mem[address] and data_valid = 1 next cycle.
  - cs = 1: no access. data_out holds its last value and data_valid = 0.
- Read after write to the same address on consecutive cycles returns the newly written value. No bypass is needed because the write lands first.
- data_out is never driven to high-Z by this block. Bus tri-stating belongs to the top level.
- Address wrap does not apply: the full ADDR_WIDTH range is valid, with no out-of-range case.
- Reset mid-operation:
  - Takes effect immediately (asynchronous) and aborts any sweep or access.
  - Memory contents are not reset directly; the next sweep clears them.
  - A write on the same edge that reset asserts is not guaranteed.

## Timing
- Reset values: data_out = 0, data_valid = 0, busy = 1, state = CLEAR, ptr = 0.
- Sweep after reset release:
  - The first rising edge with reset_n = 1 writes location 0.
  - Edge k writes location k-1.
  - Edge DEPTH (128 by default) writes location 127. busy reads 0 after this edge.
- A request presented on an edge where busy was 1 is dropped, with no deferred service.
- Read latency is 1 cycle: address sampled at edge n, data_out and data_valid valid after edge n, data_valid cleared after edge n+1 unless another read occurs.
- Back-to-back reads on every cycle give data_valid high continuously, with new data each cycle.
- Write completes at its edge. A read on the following edge sees the new value.

## Test plan
- Reset, then 128 clocks: busy stays 1 through edge 127 and drops after edge 128. Reading addresses 0, 64 and 127 then returns 8'h00 with a data_valid pulse each.
- Write 8'hA5 to address 7, then read address 7 on the next cycle: data_out = 8'hA5 and data_valid = 1 exactly one cycle after the read edge.
- During the sweep (edge 10), issue a write of 8'h3C to address 3. After busy falls, read address 3: data_out = 8'h00, proving the request was dropped.
- Write 8'h11, 8'h22, 8'h33 to addresses 0, 1, 2, then read 0, 1, 2 back-to-back: data_out sequence is 11, 22, 33, and data_valid stays high for 3 consecutive cycles.
- Hold cs = 1 for 5 cycles after a read of 8'h22: data_out holds 8'h22 and data_valid = 0 throughout.
- Write 8'hFF to address 127, then assert reset_n = 0 mid-sweep of a second reset and release it: busy = 1 and data_out = 0 immediately. After 128 edges, reading address 127 returns 8'h00.
